// File: rtl/sonic_rx_ctl_66.sv
// Receive control path: bit-packs 66-bit rx blocks into 128-bit words and writes them into the
// rx circular buffer. It also tracks occupancy against the host DMA read pointer.
module sonic_rx_ctl_66 #(
    parameter int                    ADDR_WIDTH = 13,
    parameter int                    USED_WIDTH = 14,
    parameter logic [USED_WIDTH-1:0] THRESHOLD  = 14'h200
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ena,
    input  logic                  block_lock,
    input  logic [65:0]           data_in,
    input  logic                  data_valid,
    input  logic [ADDR_WIDTH-1:0] host_rptr,
    output logic [127:0]          wr_data,
    output logic [ADDR_WIDTH-1:0] wr_address,
    output logic                  wr_en,
    output logic [USED_WIDTH-1:0] used_qwords,
    output logic                  full,
    output logic                  dma_ready,
    output logic                  overflow,
    output logic [15:0]           drop_count
);
    // The accumulator holds up to 127 leftover bits plus one 66-bit block.
    localparam int ACC_WIDTH = 194;

    logic [ACC_WIDTH-1:0]  acc;
    logic [ACC_WIDTH-1:0]  acc_sum;
    logic [7:0]            cnt;
    logic [8:0]            cnt_sum;
    logic [8:0]            cnt_wrap;
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] words_used;
    logic                  accept;
    logic                  emit;
    logic                  space_full;
    logic                  do_write;
    logic                  do_drop;

    // The input side has no ready: a block is taken on any edge where ena, block_lock and
    // data_valid are all high. Buffer space is judged from the live pointers, so two
    // emissions on consecutive edges can never overwrite unread data.
    always_comb begin
        accept     = ena & block_lock & data_valid;
        acc_sum    = acc | (ACC_WIDTH'(data_in) << cnt);
        cnt_sum    = {1'b0, cnt} + 9'd66;
        cnt_wrap   = cnt_sum - 9'd128;
        emit       = accept & (cnt_sum >= 9'd128);
        words_used = wptr - host_rptr;
        space_full = &words_used;
        do_write   = emit & ~space_full;
        do_drop    = emit & space_full;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc         <= '0;
            cnt         <= '0;
            wptr        <= '0;
            wr_data     <= '0;
            wr_address  <= '0;
            wr_en       <= 1'b0;
            used_qwords <= '0;
            full        <= 1'b0;
            dma_ready   <= 1'b0;
            overflow    <= 1'b0;
            drop_count  <= '0;
        end else begin
            if (!block_lock) begin
                acc <= '0;
                cnt <= '0;
            end else if (accept) begin
                if (emit) begin
                    acc <= acc_sum >> 128;
                    cnt <= cnt_wrap[7:0];
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt_sum[7:0];
                end
            end

            wr_en <= do_write;
            if (do_write) begin
                wr_data    <= acc_sum[127:0];
                wr_address <= wptr;
                wptr       <= wptr + 1'b1;
            end

            // A dropped word still advances the accumulator; only the write is lost.
            if (do_drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end

            used_qwords <= USED_WIDTH'({words_used, 1'b0});
            full        <= space_full;

            if (!dma_ready && (used_qwords >= THRESHOLD)) dma_ready <= 1'b1;
            else if (dma_ready && (used_qwords == '0))    dma_ready <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sonic_rx_ctl_66.sv
// Bench for sonic_rx_ctl_66: random blocks against a bit-stream reference model, scenario tasks
// with inline checks, and a scoreboard of buffer writes.
module tb_sonic_rx_ctl_66;
    logic         clock = 1'b0;
    logic         reset;
    logic         ena;
    logic         block_lock;
    logic [65:0]  data_in;
    logic         data_valid;
    logic [12:0]  host_rptr;
    logic [127:0] wr_data;
    logic [12:0]  wr_address;
    logic         wr_en;
    logic [13:0]  used_qwords;
    logic         full;
    logic         dma_ready;
    logic         overflow;
    logic [15:0]  drop_count;

    sonic_rx_ctl_66 dut (
        .clock(clock), .reset(reset), .ena(ena), .block_lock(block_lock),
        .data_in(data_in), .data_valid(data_valid), .host_rptr(host_rptr),
        .wr_data(wr_data), .wr_address(wr_address), .wr_en(wr_en),
        .used_qwords(used_qwords), .full(full), .dma_ready(dma_ready),
        .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: the accepted bits as one serial stream, plus the buffer pointer.
    logic         stream_q[$];
    logic [140:0] exp_q[$];
    logic [140:0] obs_q[$];
    int           model_wptr  = 0;
    int           model_drops = 0;
    bit           last_emit;
    bit           last_write;

    always @(negedge clock) begin
        if (wr_en === 1'b1) obs_q.push_back({wr_address, wr_data});
    end

    function automatic logic [65:0] rand66();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[65:0];
    endfunction

    task automatic model_accept(input logic [65:0] d);
        logic [127:0] w;
        last_emit  = 1'b0;
        last_write = 1'b0;
        for (int b = 0; b < 66; b++) stream_q.push_back(d[b]);
        if (stream_q.size() >= 128) begin
            for (int b = 0; b < 128; b++) w[b] = stream_q.pop_front();
            last_emit = 1'b1;
            if (((model_wptr - int'(host_rptr)) & 8191) == 8191) begin
                model_drops++;
            end else begin
                exp_q.push_back({13'(model_wptr), w});
                model_wptr = (model_wptr + 1) & 8191;
                last_write = 1'b1;
            end
        end
    endtask

    // One accepted block per call; returns 1 ns after the accepting edge.
    task automatic send(input logic [65:0] d);
        ena        = 1'b1;
        block_lock = 1'b1;
        data_valid = 1'b1;
        data_in    = d;
        @(posedge clock);
        model_accept(d);
        #1;
        data_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        data_valid = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic lock_drop();
        data_valid = 1'b1;
        data_in    = rand66();
        block_lock = 1'b0;
        @(posedge clock);
        stream_q.delete();
        #1;
        block_lock = 1'b1;
        data_valid = 1'b0;
    endtask

    function automatic int write_mismatches();
        int n;
        int m;
        n = (obs_q.size() > exp_q.size()) ? obs_q.size() - exp_q.size()
                                          : exp_q.size() - obs_q.size();
        m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) if (obs_q[i] !== exp_q[i]) n++;
        obs_q.delete();
        exp_q.delete();
        return n;
    endfunction

    task automatic test_reset();
        reset = 1'b1; ena = 1'b0; block_lock = 1'b0; data_valid = 1'b0;
        data_in = '0; host_rptr = '0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({wr_en, wr_address, wr_data} !== 142'd0) begin
            errors++; $display("FAIL reset_write_port got %h want 0", {wr_en, wr_address, wr_data});
        end
        reset = 1'b0;
        block_lock = 1'b1;
        idle(2);
        checks++;
        if ({used_qwords, full, dma_ready, overflow, drop_count, wr_en} !== 35'd0) begin
            errors++;
            $display("FAIL reset_status got used=%0d full=%b rdy=%b ovf=%b drops=%0d wr_en=%b want all 0",
                     used_qwords, full, dma_ready, overflow, drop_count, wr_en);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        host_rptr = '0;
        for (int i = 0; i < 64; i++) begin
            send({2'b01, 64'(i)});
            if (i == 0) begin
                checks++;
                if (wr_en !== 1'b0) begin
                    errors++; $display("FAIL b2b_first_block_no_word got wr_en=%b want 0", wr_en);
                end
            end
            if (i == 1) begin
                checks++;
                if (wr_en !== 1'b1 || wr_address !== 13'd0) begin
                    errors++; $display("FAIL b2b_first_word got wr_en=%b addr=%0d want 1/0", wr_en, wr_address);
                end
            end
        end
        idle(2);
        checks++;
        if (used_qwords !== 14'd66) begin
            errors++; $display("FAIL b2b_used got %0d want 66", used_qwords);
        end
        checks++;
        if (obs_q.size() != 33 || obs_q[obs_q.size()-1][140:128] !== 13'd32) begin
            errors++; $display("FAIL b2b_word_count got %0d words want 33 ending at address 32", obs_q.size());
        end
        n = write_mismatches();
        checks++;
        if (n != 0) begin
            errors++; $display("FAIL b2b_stream got %0d bad words want 0", n);
        end
    endtask

    task automatic test_dma_hysteresis();
        int guard = 0;
        int n;
        while (model_wptr != 256 && guard < 2000) begin
            send(rand66());
            guard++;
        end
        checks++;
        if (model_wptr != 256) begin
            errors++; $display("FAIL hyst_fill_timeout got wptr=%0d want 256", model_wptr);
        end
        idle(1);
        checks++;
        if (used_qwords !== 14'h200 || dma_ready !== 1'b0) begin
            errors++; $display("FAIL hyst_at_threshold got used=%h rdy=%b want 200/0", used_qwords, dma_ready);
        end
        idle(1);
        checks++;
        if (dma_ready !== 1'b1) begin
            errors++; $display("FAIL hyst_rise got rdy=%b want 1", dma_ready);
        end
        host_rptr = 13'(model_wptr - 255);
        idle(1);
        checks++;
        if (used_qwords !== 14'h1FE || dma_ready !== 1'b1) begin
            errors++; $display("FAIL hyst_hold got used=%h rdy=%b want 1fe/1", used_qwords, dma_ready);
        end
        host_rptr = 13'(model_wptr);
        idle(1);
        checks++;
        if (used_qwords !== 14'd0 || dma_ready !== 1'b1) begin
            errors++; $display("FAIL hyst_empty got used=%h rdy=%b want 0/1", used_qwords, dma_ready);
        end
        idle(1);
        checks++;
        if (dma_ready !== 1'b0) begin
            errors++; $display("FAIL hyst_fall got rdy=%b want 0", dma_ready);
        end
        n = write_mismatches();
        checks++;
        if (n != 0) begin
            errors++; $display("FAIL hyst_stream got %0d bad words want 0", n);
        end
    endtask

    task automatic test_full_overflow();
        int guard = 0;
        int n;
        host_rptr = '0;
        while (model_wptr != 8191 && guard < 20000) begin
            send(rand66());
            guard++;
        end
        idle(1);
        checks++;
        if (model_wptr != 8191 || full !== 1'b1 || used_qwords !== 14'd16382 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_reached got wptr=%0d full=%b used=%0d ovf=%b want 8191/1/16382/0",
                     model_wptr, full, used_qwords, overflow);
        end
        guard = 0;
        do begin send(rand66()); guard++; end while (!last_emit && guard < 10);
        checks++;
        if (wr_en !== 1'b0 || overflow !== 1'b1 || drop_count !== 16'd1 || full !== 1'b1) begin
            errors++;
            $display("FAIL full_drop got wr_en=%b ovf=%b drops=%0d full=%b want 0/1/1/1",
                     wr_en, overflow, drop_count, full);
        end
        host_rptr = 13'd1;
        guard = 0;
        do begin send(rand66()); guard++; end while (!last_emit && guard < 10);
        checks++;
        if (wr_en !== 1'b1 || wr_address !== 13'd8191) begin
            errors++; $display("FAIL full_resume got wr_en=%b addr=%0d want 1/8191", wr_en, wr_address);
        end
        idle(1);
        n = write_mismatches();
        checks++;
        if (n != 0) begin
            errors++; $display("FAIL full_stream got %0d bad words want 0", n);
        end
    endtask

    task automatic test_wrap();
        int guard = 0;
        int bad = 0;
        int bad_val = 0;
        int prev;
        int n;
        bit passed_top = 1'b0;
        bit done = 1'b0;
        host_rptr = 13'(model_wptr - 100);
        idle(2);
        while (!done && guard < 20000) begin
            prev = model_wptr;
            send(rand66());
            guard++;
            if (used_qwords !== 14'd200) begin
                bad++; bad_val = int'(used_qwords);
            end
            if (last_write) begin
                if (prev == 8191) passed_top = 1'b1;
                else if (prev == 0 && passed_top) begin
                    done = 1'b1;
                    checks++;
                    if (wr_en !== 1'b1 || wr_address !== 13'd0) begin
                        errors++; $display("FAIL wrap_address got wr_en=%b addr=%0d want 1/0", wr_en, wr_address);
                    end
                end
                host_rptr = 13'(model_wptr - 100);
            end
        end
        checks++;
        if (!done || bad != 0) begin
            errors++; $display("FAIL wrap_used got %0d bad cycles (last used=%0d) done=%b want 0 bad, 200", bad, bad_val, done);
        end
        idle(1);
        n = write_mismatches();
        checks++;
        if (n != 0) begin
            errors++; $display("FAIL wrap_stream got %0d bad words want 0", n);
        end
    endtask

    task automatic test_ena_hold();
        logic [65:0]  a;
        logic [65:0]  b;
        logic [127:0] want;
        lock_drop();
        a = rand66();
        b = rand66();
        send(a);
        ena = 1'b0; data_valid = 1'b1; data_in = rand66();
        @(posedge clock);
        #1;
        ena = 1'b1; data_valid = 1'b0;
        checks++;
        if (wr_en !== 1'b0) begin
            errors++; $display("FAIL ena_hold_no_word got wr_en=%b want 0", wr_en);
        end
        send(b);
        want = {b[61:0], a};
        checks++;
        if (wr_en !== 1'b1 || wr_data !== want) begin
            errors++; $display("FAIL ena_hold_word got wr_en=%b data=%h want 1/%h", wr_en, wr_data, want);
        end
        idle(1);
        void'(write_mismatches());
    endtask

    task automatic test_lock_pulse();
        logic [65:0]  a;
        logic [65:0]  b;
        logic [127:0] want;
        int           n;
        send(rand66());
        send(rand66());
        lock_drop();
        send(rand66());
        lock_drop();
        a = rand66();
        b = rand66();
        send(a);
        checks++;
        if (wr_en !== 1'b0) begin
            errors++; $display("FAIL lock_no_word_before_b got wr_en=%b want 0", wr_en);
        end
        send(b);
        want = {b[61:0], a};
        checks++;
        if (wr_en !== 1'b1 || wr_data !== want || wr_address !== 13'(model_wptr - 1)) begin
            errors++;
            $display("FAIL lock_first_word got wr_en=%b addr=%0d data=%h want 1/%0d/%h",
                     wr_en, wr_address, wr_data, 13'(model_wptr - 1), want);
        end
        checks++;
        if (overflow !== 1'b1 || drop_count !== 16'd1) begin
            errors++; $display("FAIL lock_sticky got ovf=%b drops=%0d want 1/1", overflow, drop_count);
        end
        idle(1);
        n = write_mismatches();
        checks++;
        if (n != 0) begin
            errors++; $display("FAIL lock_stream got %0d bad words want 0", n);
        end
    endtask

    task automatic test_reset_mid();
        logic [65:0]  a;
        logic [65:0]  b;
        logic [127:0] want;
        lock_drop();
        send(rand66());
        checks++;
        if (dma_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_precondition got rdy=%b want 1", dma_ready);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({wr_data, wr_address, wr_en, used_qwords, full, dma_ready, overflow, drop_count} !== 175'd0) begin
            errors++;
            $display("FAIL rst_mid_async got wr_en=%b addr=%0d used=%0d full=%b rdy=%b ovf=%b drops=%0d want all 0",
                     wr_en, wr_address, used_qwords, full, dma_ready, overflow, drop_count);
        end
        host_rptr = '0;
        stream_q.delete();
        model_wptr = 0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        obs_q.delete();
        exp_q.delete();
        a = rand66();
        b = rand66();
        send(a);
        checks++;
        if (wr_en !== 1'b0) begin
            errors++; $display("FAIL rst_mid_no_stale_word got wr_en=%b want 0", wr_en);
        end
        send(b);
        want = {b[61:0], a};
        checks++;
        if (wr_en !== 1'b1 || wr_address !== 13'd0 || wr_data !== want) begin
            errors++;
            $display("FAIL rst_mid_first_word got wr_en=%b addr=%0d data=%h want 1/0/%h", wr_en, wr_address, wr_data, want);
        end
        idle(2);
        checks++;
        if (used_qwords !== 14'd2) begin
            errors++; $display("FAIL rst_mid_used got %0d want 2", used_qwords);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_dma_hysteresis();
        test_full_overflow();
        test_wrap();
        test_ena_hold();
        test_lock_pulse();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
